// File: rtl/rat_ckpt_if.sv
// Rename-stage bus between the rename logic and the alias table: rename slots, checkpoints and recovery.
interface rat_ckpt_if #(
  parameter int unsigned ARCH_ENTRY   = 32,
  parameter int unsigned ARCH_WIDTH   = $clog2(ARCH_ENTRY),
  parameter int unsigned PRF_ENTRY    = 128,
  parameter int unsigned PRF_WIDTH    = $clog2(PRF_ENTRY),
  parameter int unsigned RENAME_WIDTH = 2,
  parameter int unsigned NUM_CKPT     = 4,
  parameter int unsigned CKPT_WIDTH   = $clog2(NUM_CKPT)
);
  logic [RENAME_WIDTH-1:0]            rn_valid;
  logic [RENAME_WIDTH*ARCH_WIDTH-1:0] rn_rd;
  logic [RENAME_WIDTH*PRF_WIDTH-1:0]  rn_pd;
  logic [RENAME_WIDTH*ARCH_WIDTH-1:0] rn_rs1;
  logic [RENAME_WIDTH*ARCH_WIDTH-1:0] rn_rs2;
  logic [RENAME_WIDTH*PRF_WIDTH-1:0]  rn_ps1;
  logic [RENAME_WIDTH*PRF_WIDTH-1:0]  rn_ps2;
  logic [RENAME_WIDTH*PRF_WIDTH-1:0]  rn_pd_old;
  logic                               ckpt_take;
  logic [CKPT_WIDTH-1:0]              ckpt_id;
  logic                               ckpt_full;
  logic                               ckpt_release;
  logic                               restore_en;
  logic [CKPT_WIDTH-1:0]              restore_id;
  logic                               flush_en;
  logic [ARCH_ENTRY*PRF_WIDTH-1:0]    commit_map;

  modport master (
    output rn_valid, rn_rd, rn_pd, rn_rs1, rn_rs2, ckpt_take, ckpt_release,
           restore_en, restore_id, flush_en, commit_map,
    input  rn_ps1, rn_ps2, rn_pd_old, ckpt_id, ckpt_full
  );

  modport slave (
    input  rn_valid, rn_rd, rn_pd, rn_rs1, rn_rs2, ckpt_take, ckpt_release,
           restore_en, restore_id, flush_en, commit_map,
    output rn_ps1, rn_ps2, rn_pd_old, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rat_ckpt.sv
// Multi-port register alias table with intra-group forwarding and a circular
// buffer of map checkpoints for mispredict restore and full flush to the committed map.
module rat_ckpt #(
  parameter int unsigned ARCH_ENTRY   = 32,
  parameter int unsigned ARCH_WIDTH   = $clog2(ARCH_ENTRY),
  parameter int unsigned PRF_ENTRY    = 128,
  parameter int unsigned PRF_WIDTH    = $clog2(PRF_ENTRY),
  parameter int unsigned RENAME_WIDTH = 2,
  parameter int unsigned NUM_CKPT     = 4,
  parameter int unsigned CKPT_WIDTH   = $clog2(NUM_CKPT)
) (
  input  logic       clk,
  input  logic       rst,
  rat_ckpt_if.slave  bus
);
  localparam int unsigned CNT_W = CKPT_WIDTH + 1;

  typedef logic [PRF_WIDTH-1:0]  tag_t;
  typedef logic [ARCH_WIDTH-1:0] areg_t;

  tag_t                  map_q   [ARCH_ENTRY];
  tag_t                  map_nxt [ARCH_ENTRY];
  tag_t                  ckpt_q  [NUM_CKPT][ARCH_ENTRY];
  logic [CKPT_WIDTH-1:0] head_q, tail_q, tail_d, restore_dist;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q;
  logic                  rel_ok, take_ok;

  areg_t rd_w  [RENAME_WIDTH];
  areg_t rs1_w [RENAME_WIDTH];
  areg_t rs2_w [RENAME_WIDTH];
  tag_t  pd_w  [RENAME_WIDTH];

  for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_slot
    tag_t ps1_s, ps2_s, pdo_s;

    assign rd_w[k]  = bus.rn_rd [k*ARCH_WIDTH +: ARCH_WIDTH];
    assign rs1_w[k] = bus.rn_rs1[k*ARCH_WIDTH +: ARCH_WIDTH];
    assign rs2_w[k] = bus.rn_rs2[k*ARCH_WIDTH +: ARCH_WIDTH];
    assign pd_w[k]  = bus.rn_pd [k*PRF_WIDTH +: PRF_WIDTH];

    // Map lookup, overridden by older slots in the group (younger ones scanned last win).
    always_comb begin
      ps1_s = map_q[rs1_w[k]];
      ps2_s = map_q[rs2_w[k]];
      pdo_s = map_q[rd_w[k]];
      for (int j = 0; j < int'(k); j++) begin
        if (bus.rn_valid[j] && (rd_w[j] != '0)) begin
          if (rd_w[j] == rs1_w[k]) ps1_s = pd_w[j];
          if (rd_w[j] == rs2_w[k]) ps2_s = pd_w[j];
          if (rd_w[j] == rd_w[k])  pdo_s = pd_w[j];
        end
      end
      if (rs1_w[k] == '0) ps1_s = '0;
      if (rs2_w[k] == '0) ps2_s = '0;
      if (rd_w[k]  == '0) pdo_s = '0;
    end

    assign bus.rn_ps1   [k*PRF_WIDTH +: PRF_WIDTH] = ps1_s;
    assign bus.rn_ps2   [k*PRF_WIDTH +: PRF_WIDTH] = ps2_s;
    assign bus.rn_pd_old[k*PRF_WIDTH +: PRF_WIDTH] = pdo_s;
  end

  // Post-rename map; the highest colliding slot wins.
  always_comb begin
    map_nxt = map_q;
    for (int k = 0; k < int'(RENAME_WIDTH); k++) begin
      if (bus.rn_valid[k] && (rd_w[k] != '0)) map_nxt[rd_w[k]] = pd_w[k];
    end
  end

  // Checkpoint pointer bookkeeping; a take is accepted when full only if a release frees the head.
  always_comb begin
    rel_ok       = bus.ckpt_release && (count_q != '0);
    take_ok      = bus.ckpt_take && !bus.restore_en && (!full_q || rel_ok);
    restore_dist = bus.restore_id - head_q;
    if (bus.restore_en) begin
      tail_d  = bus.restore_id + CKPT_WIDTH'(1);
      count_d = CNT_W'(restore_dist) + CNT_W'(1) - CNT_W'(rel_ok);
    end else begin
      tail_d  = tail_q + CKPT_WIDTH'(take_ok);
      count_d = count_q + CNT_W'(take_ok) - CNT_W'(rel_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_ENTRY); i++) map_q[i] <= tag_t'(i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (bus.flush_en) begin
      for (int i = 0; i < int'(ARCH_ENTRY); i++) map_q[i] <= bus.commit_map[i*PRF_WIDTH +: PRF_WIDTH];
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (bus.restore_en) map_q <= ckpt_q[bus.restore_id];
      else                map_q <= map_nxt;
      head_q  <= head_q + CKPT_WIDTH'(rel_ok);
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(NUM_CKPT));
    end
  end

  // Snapshot storage carries no reset; contents only matter once a slot is live.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush_en && take_ok) ckpt_q[tail_q] <= map_nxt;
  end

  assign bus.ckpt_full = full_q;
  assign bus.ckpt_id   = tail_q;

  a_restore_live: assert property (@(posedge clk) disable iff (rst)
    (bus.restore_en && !bus.flush_en) |-> (CNT_W'(restore_dist) < count_q))
    else $error("restore_id outside live checkpoint range");
endmodule

// File: tb/tb_rat_ckpt.sv
// Randomized scoreboard bench for rat_ckpt against a queue-based reference model.
module tb_rat_ckpt;
  localparam int unsigned AE = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 7;
  localparam int unsigned RW = 2;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rat_ckpt_if bus ();
  rat_ckpt dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [RW-1:0]    v;
    logic [RW*PW-1:0] ps1;
    logic [RW*PW-1:0] ps2;
    logic [RW*PW-1:0] pdo;
    logic [1:0]       id;
    logic             full;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a flat map plus a queue of live snapshots, oldest first.
  logic [PW-1:0]    mmap [AE];
  logic [AE*PW-1:0] snaps[$];
  int               ckid[$];
  int               mtail;

  // Stimulus for the current cycle
  logic [RW-1:0]    v;
  logic [AW-1:0]    rd [RW];
  logic [AW-1:0]    rs1[RW];
  logic [AW-1:0]    rs2[RW];
  logic [PW-1:0]    pd [RW];
  logic             take, rel, rest, fl;
  logic [1:0]       rid;
  logic [AE*PW-1:0] cmap;

  task automatic chk(input string nm, input int k, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s slot%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      for (int k = 0; k < int'(RW); k++) begin
        if (mon_e.v[k]) begin
          chk("ps1",    k, bus.rn_ps1   [k*PW +: PW], mon_e.ps1[k*PW +: PW]);
          chk("ps2",    k, bus.rn_ps2   [k*PW +: PW], mon_e.ps2[k*PW +: PW]);
          chk("pd_old", k, bus.rn_pd_old[k*PW +: PW], mon_e.pdo[k*PW +: PW]);
        end
      end
      chk("ckpt_id",   0, PW'(bus.ckpt_id),   PW'(mon_e.id));
      chk("ckpt_full", 0, PW'(bus.ckpt_full), PW'(mon_e.full));
    end
  end

  task automatic clr();
    v = '0; take = 1'b0; rel = 1'b0; rest = 1'b0; fl = 1'b0; rid = '0; cmap = '0;
    for (int k = 0; k < int'(RW); k++) begin
      rd[k] = '0; rs1[k] = '0; rs2[k] = '0; pd[k] = '0;
    end
  endtask

  task automatic drive();
    bus.rn_valid     = v;
    bus.ckpt_take    = take;
    bus.ckpt_release = rel;
    bus.restore_en   = rest;
    bus.restore_id   = rid;
    bus.flush_en     = fl;
    bus.commit_map   = cmap;
    for (int k = 0; k < int'(RW); k++) begin
      bus.rn_rd [k*AW +: AW] = rd[k];
      bus.rn_rs1[k*AW +: AW] = rs1[k];
      bus.rn_rs2[k*AW +: AW] = rs2[k];
      bus.rn_pd [k*PW +: PW] = pd[k];
    end
  endtask

  function automatic logic [PW-1:0] fwd(input int k, input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int j = k - 1; j >= 0; j--) if (v[j] && rd[j] == a) return pd[j];
    return mmap[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(AE); i++) mmap[i] = PW'(i);
    snaps.delete();
    ckid.delete();
    mtail = 0;
  endtask

  task automatic model_update();
    logic [AE*PW-1:0] snap;
    bit relok, takeok;
    int idx;
    if (fl) begin
      for (int i = 0; i < int'(AE); i++) mmap[i] = cmap[i*PW +: PW];
      snaps.delete();
      ckid.delete();
      mtail = 0;
      return;
    end
    relok = rel && (ckid.size() > 0);
    if (rest) begin
      idx = -1;
      foreach (ckid[i]) if (ckid[i] == int'(rid)) idx = i;
      if (idx >= 0) begin
        snap = snaps[idx];
        for (int i = 0; i < int'(AE); i++) mmap[i] = snap[i*PW +: PW];
        while (ckid.size() > idx + 1) begin
          void'(ckid.pop_back());
          void'(snaps.pop_back());
        end
      end
      mtail = (int'(rid) + 1) % NC;
      if (relok) begin
        void'(ckid.pop_front());
        void'(snaps.pop_front());
      end
    end else begin
      takeok = take && ((ckid.size() < NC) || relok);
      for (int k = 0; k < int'(RW); k++) if (v[k] && rd[k] != '0) mmap[rd[k]] = pd[k];
      if (relok) begin
        void'(ckid.pop_front());
        void'(snaps.pop_front());
      end
      if (takeok) begin
        for (int i = 0; i < int'(AE); i++) snap[i*PW +: PW] = mmap[i];
        snaps.push_back(snap);
        ckid.push_back(mtail);
        mtail = (mtail + 1) % NC;
      end
    end
  endtask

  // Issue one cycle: drive, push the expected response, advance the model.
  task automatic step();
    exp_t e;
    drive();
    e.v = v;
    for (int k = 0; k < int'(RW); k++) begin
      e.ps1[k*PW +: PW] = fwd(k, rs1[k]);
      e.ps2[k*PW +: PW] = fwd(k, rs2[k]);
      e.pdo[k*PW +: PW] = (rd[k] == '0) ? '0 : fwd(k, rd[k]);
    end
    e.id   = 2'(mtail);
    e.full = (ckid.size() == NC);
    sb.push_back(e);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    do_reset();

    // Reset identity map
    clr(); v = 2'b01; rs1[0] = 5; rs2[0] = 0; rd[0] = 7; pd[0] = 20; step();
    // Intra-group forwarding, then the committed result
    clr(); v = 2'b11; rd[0] = 3; pd[0] = 40; rs1[1] = 3; rd[1] = 3; pd[1] = 41; step();
    clr(); v = 2'b01; rs1[0] = 3; step();
    // Checkpoint then restore
    clr(); v = 2'b01; rd[0] = 4; pd[0] = 50; take = 1; step();
    clr(); v = 2'b01; rd[0] = 4; pd[0] = 60; rs1[0] = 4; step();
    clr(); v = 2'b01; rd[0] = 4; pd[0] = 61; take = 1; rest = 1; rid = 0; step();
    clr(); v = 2'b01; rs1[0] = 4; rd[0] = 4; pd[0] = 62; step();
    // Fill, over-take, take+release while full
    for (int i = 0; i < 3; i++) begin
      clr(); v = 2'b01; rd[0] = AW'(8 + i); pd[0] = PW'(80 + i); take = 1; step();
    end
    clr(); v = 2'b01; rs1[0] = 8; take = 1; step();
    clr(); take = 1; rel = 1; step();
    clr(); step();
    // Flush overriding restore and rename
    clr(); rel = 1; step();
    clr(); v = 2'b01; rd[0] = 9; pd[0] = 70; step();
    clr(); v = 2'b01; rs1[0] = 9; step();
    clr();
    for (int i = 0; i < int'(AE); i++) cmap[i*PW +: PW] = PW'($urandom_range(0, 127));
    cmap[9*PW +: PW] = 12;
    fl = 1; rest = 1; rid = 2'(ckid[0]); take = 1; rel = 1;
    v = 2'b11; rd[0] = 9; pd[0] = 71; rd[1] = 10; pd[1] = 72; step();
    clr(); v = 2'b11; rs1[0] = 9; rs2[0] = 10; rs1[1] = 9; rd[1] = 9; pd[1] = 1; step();
    // x0 is never renamed
    clr(); v = 2'b11; rd[0] = 0; pd[0] = 99; rs1[1] = 0; rs2[1] = 0; rd[1] = 0; pd[1] = 98; step();
    clr(); v = 2'b01; rs1[0] = 0; rd[0] = 0; step();

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      clr();
      v = 2'($urandom_range(0, 3));
      for (int k = 0; k < int'(RW); k++) begin
        rd[k] = rnd_reg(); rs1[k] = rnd_reg(); rs2[k] = rnd_reg();
        pd[k] = PW'($urandom_range(0, 127));
      end
      take = ($urandom_range(0, 3) == 0);
      rel  = ($urandom_range(0, 4) == 0);
      if (ckid.size() > 0 && $urandom_range(0, 9) == 0) begin
        rest = 1;
        rid  = 2'(ckid[$urandom_range(0, ckid.size() - 1)]);
      end
      if ($urandom_range(0, 39) == 0) begin
        fl = 1;
        for (int i = 0; i < int'(AE); i++) cmap[i*PW +: PW] = PW'($urandom_range(0, 127));
      end
      step();
    end

    clr(); step();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
